// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO read port and sticky error flags between the UART receiver and the core.
interface uart_rx_fifo_if;
  logic [7:0] o_data;
  logic       o_empty;
  logic       i_rd;
  logic       o_frame_err;
  logic       o_overflow;
  logic       i_clr_err;

  // Receiver side: presents FIFO head and flags, accepts pop and clear strobes.
  modport slave (
    output o_data,
    output o_empty,
    output o_frame_err,
    output o_overflow,
    input  i_rd,
    input  i_clr_err
  );

  // Consumer side: reads head and flags, drives pop and clear strobes.
  modport master (
    input  o_data,
    input  o_empty,
    input  o_frame_err,
    input  o_overflow,
    output i_rd,
    output i_clr_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int unsigned G_BAUD_DIV   = 87,
  parameter int unsigned G_FIFO_DEPTH = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_uart_rx,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned HALF = (G_BAUD_DIV - 1) / 2;
  localparam int unsigned CW   = $clog2(G_BAUD_DIV);
  localparam int unsigned AW   = $clog2(G_FIFO_DEPTH);
  localparam int unsigned PW   = AW + 1;

  // The counter is examined for zero on the edge it is observed, so the
  // start-bit load is one short to land the centre sample on N0+HALF.
  localparam logic [CW-1:0] START_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LOAD   = CW'(G_BAUD_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            rx_meta;
  logic            s_rx;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      mem [G_FIFO_DEPTH];
  logic            frame_err;
  logic            overflow;

  logic            cnt_zero_c;
  logic            stop_sample_c;
  logic            wr_req_c;
  logic            ferr_set_c;
  logic            empty_c;
  logic            full_c;
  logic            rd_en_c;
  logic            wr_en_c;
  logic            ovf_set_c;

  assign cnt_zero_c    = (cnt == '0);
  assign stop_sample_c = (state == ST_STOP) && cnt_zero_c;
  assign wr_req_c      = stop_sample_c && s_rx;
  assign ferr_set_c    = stop_sample_c && !s_rx;

  assign empty_c  = (wr_ptr == rd_ptr);
  assign full_c   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en_c  = bus.i_rd && !empty_c;
  // A pop on the same edge frees the slot, so a write into a full FIFO still lands.
  assign wr_en_c  = wr_req_c && (!full_c || rd_en_c);
  assign ovf_set_c = wr_req_c && full_c && !rd_en_c;

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      s_rx    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      s_rx    <= rx_meta;
    end
  end

  // Frame FSM: start validation, mid-bit sampling, stop check and break hold-off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!s_rx) begin
            state <= ST_START;
            cnt   <= START_LOAD;
          end
        end
        ST_START: begin
          if (cnt_zero_c) begin
            if (s_rx) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              cnt     <= BIT_LOAD;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_zero_c) begin
            shreg <= {s_rx, shreg[7:1]};
            cnt   <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_zero_c) begin
            state <= s_rx ? ST_IDLE : ST_BREAK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_BREAK: begin
          if (s_rx) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en_c) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (wr_en_c) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // Sticky error flags; a new event outranks a clear on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ferr_set_c)         frame_err <= 1'b1;
      else if (bus.i_clr_err) frame_err <= 1'b0;
      if (ovf_set_c)          overflow  <= 1'b1;
      else if (bus.i_clr_err) overflow  <= 1'b0;
    end
  end

  assign bus.o_data      = mem[rd_ptr[AW-1:0]];
  assign bus.o_empty     = empty_c;
  assign bus.o_frame_err = frame_err;
  assign bus.o_overflow  = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bytes expected in the FIFO are queued as frames are sent.
module tb_uart_rx_fifo;

  localparam int unsigned B     = 8;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  logic rx;

  int n_cmp;
  int n_err;
  logic [7:0] exp_q [$];

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .G_BAUD_DIV   (B),
    .G_FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_uart_rx (rx),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send one 8N1 frame starting at a falling clock edge; optionally queue it
  // as expected FIFO content and optionally pop on the stop-sample edge.
  task automatic send_byte(input logic [7:0] d, input bit stop_ok, input bit store,
                           input bit rd_at_stop);
    logic [9:0] bits;
    logic [7:0] head;
    bits = {stop_ok, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (i == 9 && rd_at_stop) begin
        repeat (5) @(negedge clk);
        if (exp_q.size() == 0) begin
          check("rd_at_stop_queue", 32'(exp_q.size()), 32'd1);
        end else begin
          head = exp_q.pop_front();
          check("rd_at_stop_head", 32'(bus.o_data), 32'(head));
        end
        bus.i_rd = 1'b1;
        @(negedge clk);
        bus.i_rd = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (B) @(negedge clk);
      end
    end
    if (store) exp_q.push_back(d);
  endtask

  // Pop everything the FIFO holds and compare against the scoreboard.
  task automatic drain(input string tag);
    logic [7:0] want;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (bus.o_empty) break;
      if (exp_q.size() == 0) begin
        check({tag, "_extra"}, 32'(bus.o_data), 32'hxxxx_xxxx);
      end else begin
        want = exp_q.pop_front();
        check({tag, "_data"}, 32'(bus.o_data), 32'(want));
      end
      bus.i_rd = 1'b1;
      @(negedge clk);
      bus.i_rd = 1'b0;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_empty"}, 32'(bus.o_empty), 32'd1);
  endtask

  task automatic clear_err();
    bus.i_clr_err = 1'b1;
    @(negedge clk);
    bus.i_clr_err = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rx = 1'b1;
    rst_n = 1'b0;
    bus.i_rd = 1'b0;
    bus.i_clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", 32'(bus.o_empty), 32'd1);
    check("rst_ferr", 32'(bus.o_frame_err), 32'd0);
    check("rst_ovf", 32'(bus.o_overflow), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte
    send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
    check("a5_empty", 32'(bus.o_empty), 32'd0);
    check("a5_head", 32'(bus.o_data), 32'hA5);
    drain("a5");
    check("a5_ferr", 32'(bus.o_frame_err), 32'd0);
    check("a5_ovf", 32'(bus.o_overflow), 32'd0);

    // Back-to-back frames, no idle between them
    send_byte(8'h00, 1'b1, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b1, 1'b0);
    repeat (B) @(negedge clk);
    drain("b2b");
    check("b2b_ferr", 32'(bus.o_frame_err), 32'd0);

    // Glitch on the line plus a pop while empty
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("glitch_empty", 32'(bus.o_empty), 32'd1);
    check("glitch_ferr", 32'(bus.o_frame_err), 32'd0);
    bus.i_rd = 1'b1;
    @(negedge clk);
    bus.i_rd = 1'b0;
    check("rd_empty_empty", 32'(bus.o_empty), 32'd1);
    send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (B) @(negedge clk);
    drain("glitch");

    // Framing error followed by a long break
    send_byte(8'h81, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (20 * B) @(negedge clk);
    rx = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("ferr_set", 32'(bus.o_frame_err), 32'd1);
    check("ferr_empty", 32'(bus.o_empty), 32'd1);
    check("ferr_ovf", 32'(bus.o_overflow), 32'd0);
    clear_err();
    check("ferr_clr", 32'(bus.o_frame_err), 32'd0);

    // Overflow without a read: fifth byte dropped
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1, (i <= 4), 1'b0);
    end
    repeat (B) @(negedge clk);
    check("ovf_set", 32'(bus.o_overflow), 32'd1);
    check("ovf_ferr", 32'(bus.o_frame_err), 32'd0);
    drain("ovf");
    clear_err();
    check("ovf_clr", 32'(bus.o_overflow), 32'd0);

    // Write into a full FIFO with a pop on the same edge
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1, 1'b1, (i == 5));
    end
    repeat (B) @(negedge clk);
    check("rdw_ovf", 32'(bus.o_overflow), 32'd0);
    check("rdw_empty", 32'(bus.o_empty), 32'd0);
    drain("rdw");

    // Reset mid-frame with a stored byte and a pending frame error
    send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (2 * B) @(negedge clk);
    send_byte(8'h11, 1'b1, 1'b1, 1'b0);
    repeat (B) @(negedge clk);
    check("pre_rst_ferr", 32'(bus.o_frame_err), 32'd1);
    check("pre_rst_empty", 32'(bus.o_empty), 32'd0);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h96 >> i;
      repeat (B) @(negedge clk);
    end
    rx = 1'b1;
    repeat (B / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(bus.o_empty), 32'd1);
    check("mid_rst_ferr", 32'(bus.o_frame_err), 32'd0);
    check("mid_rst_ovf", 32'(bus.o_overflow), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("post_rst_empty", 32'(bus.o_empty), 32'd1);
    send_byte(8'h69, 1'b1, 1'b1, 1'b0);
    repeat (B) @(negedge clk);
    drain("post_rst");
    check("post_rst_ferr", 32'(bus.o_frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
